// File: rtl/speed_select_if.sv
// Bundles the two raw speed buttons and the registered speed outputs.
// The slave side is the speed selector; the master side drives the buttons.
interface speed_select_if;
   logic        btn_up;
   logic        btn_down;
   logic [31:0] period;
   logic [2:0]  level;
   logic        level_changed;

   modport slave (
      input  btn_up,
      input  btn_down,
      output period,
      output level,
      output level_changed
   );

   modport master (
      output btn_up,
      output btn_down,
      input  period,
      input  level,
      input  level_changed
   );
endinterface

// File: rtl/speed_select.sv
// Speed level selector: per-button synchronise, debounce and auto-repeat,
// then a saturating level 1..6 mapped to a step period in clk cycles.
module speed_select #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic           clk,
   input  logic           rst_n,
   speed_select_if.slave  ctl
);

   localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   logic [1:0]  raw;
   logic [1:0]  press;
   logic [2:0]  level_reg, level_next;
   logic [31:0] period_reg, period_next;
   logic        changed_reg, changed_next;

   assign raw = {ctl.btn_down, ctl.btn_up};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          sync1_reg, sync2_reg;
         logic          deb_reg, deb_d_reg, press_reg;
         logic [CW-1:0] deb_cnt_reg, rep_cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               deb_reg     <= 1'b0;
               deb_d_reg   <= 1'b0;
               press_reg   <= 1'b0;
               deb_cnt_reg <= '0;
               rep_cnt_reg <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;

               // Any sample agreeing with the debounced state restarts the count
               if (sync2_reg == deb_reg) begin
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  deb_reg     <= sync2_reg;
                  deb_cnt_reg <= '0;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + CW'(1);
               end

               deb_d_reg <= deb_reg;
               press_reg <= 1'b0;
               if (!deb_reg) begin
                  rep_cnt_reg <= '0;
               end else if (!deb_d_reg) begin
                  press_reg   <= 1'b1;
                  rep_cnt_reg <= '0;
               end else if (REPEAT_CYCLES != 0) begin
                  if (rep_cnt_reg == REP_LAST) begin
                     press_reg   <= 1'b1;
                     rep_cnt_reg <= '0;
                  end else begin
                     rep_cnt_reg <= rep_cnt_reg + CW'(1);
                  end
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   function automatic logic [31:0] period_of(input logic [2:0] lv);
      case (lv)
         3'd2:    period_of = 32'd757575;
         3'd3:    period_of = 32'd500000;
         3'd4:    period_of = 32'd375000;
         3'd5:    period_of = 32'd300000;
         3'd6:    period_of = 32'd250000;
         default: period_of = 32'd1515151;
      endcase
   endfunction

   // Simultaneous up and down presses cancel each other
   always_comb begin
      level_next = level_reg;
      if (press[0] && !press[1] && level_reg != 3'd6) begin
         level_next = level_reg + 3'd1;
      end else if (press[1] && !press[0] && level_reg != 3'd1) begin
         level_next = level_reg - 3'd1;
      end
      changed_next = (level_next != level_reg);
      period_next  = period_of(level_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg   <= 3'd1;
         period_reg  <= 32'd1515151;
         changed_reg <= 1'b0;
      end else begin
         level_reg   <= level_next;
         period_reg  <= period_next;
         changed_reg <= changed_next;
      end
   end

   assign ctl.level         = level_reg;
   assign ctl.period        = period_reg;
   assign ctl.level_changed = changed_reg;

endmodule

// File: tb/tb_speed_select.sv
// Directed bench for speed_select with a pulse scoreboard: stimulus queues the
// expected level/period/edge of each level_changed pulse, a monitor checks them.
module tb_speed_select;

   typedef struct {
      logic [2:0]  lv;
      logic [31:0] per;
      longint      at;
   } exp_t;

   logic   clk;
   logic   rst_n;
   longint edge_cnt;
   int     total;
   int     bad;
   exp_t   sb[$];

   speed_select_if sif ();

   speed_select #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES  (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ctl  (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input logic [2:0] lv, input logic [31:0] per, input longint at);
      exp_t e;
      e.lv  = lv;
      e.per = per;
      e.at  = at;
      sb.push_back(e);
   endtask

   // Monitor: every level_changed pulse must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sif.level_changed) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse actual level=%0d period=%0d required no pulse",
                     sif.level, sif.period);
         end else begin
            e = sb.pop_front();
            chk("pulse_level", longint'(sif.level), longint'(e.lv));
            chk("pulse_period", longint'(sif.period), longint'(e.per));
            if (e.at >= 0) chk("pulse_edge", edge_cnt, e.at);
            $display("pulse: level=%0d period=%0d edge=%0d", sif.level, sif.period, edge_cnt);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      sif.btn_up   = 1'b0;
      sif.btn_down = 1'b0;
      cyc(3);
      chk("rst_level", longint'(sif.level), 1);
      chk("rst_period", longint'(sif.period), 1515151);
      chk("rst_changed", longint'(sif.level_changed), 0);
      chk("rst_sb_empty", longint'(sb.size()), 0);
      rst_n = 1'b1;
      cyc(1);
      chk("post_rst_level", longint'(sif.level), 1);
      chk("post_rst_changed", longint'(sif.level_changed), 0);
   endtask

   task automatic press_up(input int hold);
      sif.btn_up = 1'b1;
      cyc(hold);
      sif.btn_up = 1'b0;
      cyc(10);
   endtask

   initial begin
      longint n;
      logic [31:0] per_tab [1:6];
      per_tab[1] = 32'd1515151; per_tab[2] = 32'd757575; per_tab[3] = 32'd500000;
      per_tab[4] = 32'd375000;  per_tab[5] = 32'd300000; per_tab[6] = 32'd250000;
      total = 0;
      bad   = 0;
      rst_n        = 1'b0;
      sif.btn_up   = 1'b0;
      sif.btn_down = 1'b0;

      // Held up button: first step after edge 7, repeat 16 cycles later
      do_reset();
      n = edge_cnt;
      sif.btn_up = 1'b1;
      expect_pulse(3'd2, 32'd757575, n + 8);
      expect_pulse(3'd3, 32'd500000, n + 24);
      cyc(27);
      sif.btn_up = 1'b0;
      cyc(12);
      chk("hold_level", longint'(sif.level), 3);
      chk("hold_period", longint'(sif.period), 500000);
      $display("txn hold_up: level=%0d period=%0d", sif.level, sif.period);

      // Three-cycle glitch is rejected
      do_reset();
      sif.btn_up = 1'b1;
      cyc(3);
      sif.btn_up = 1'b0;
      cyc(20);
      chk("glitch_level", longint'(sif.level), 1);
      chk("glitch_period", longint'(sif.period), 1515151);
      $display("txn glitch: level=%0d period=%0d", sif.level, sif.period);

      // Down at level 1 saturates; six ups reach 6 with five pulses
      do_reset();
      sif.btn_down = 1'b1;
      cyc(10);
      sif.btn_down = 1'b0;
      cyc(10);
      chk("down_sat_level", longint'(sif.level), 1);
      for (int i = 2; i <= 7; i++) begin
         n = edge_cnt;
         if (i <= 6) expect_pulse(3'(i), per_tab[i], n + 8);
         press_up(8);
         $display("txn up_press %0d: level=%0d period=%0d", i - 1, sif.level, sif.period);
      end
      chk("up_sat_level", longint'(sif.level), 6);
      chk("up_sat_period", longint'(sif.period), 250000);

      // Held through the upper limit with repeats: no pulses
      sif.btn_up = 1'b1;
      cyc(40);
      sif.btn_up = 1'b0;
      cyc(12);
      chk("held_sat_level", longint'(sif.level), 6);
      $display("txn held_sat: level=%0d period=%0d", sif.level, sif.period);

      // One down step from 6
      n = edge_cnt;
      expect_pulse(3'd5, 32'd300000, n + 8);
      sif.btn_down = 1'b1;
      cyc(8);
      sif.btn_down = 1'b0;
      cyc(10);
      chk("down_level", longint'(sif.level), 5);
      $display("txn down: level=%0d period=%0d", sif.level, sif.period);

      // Both buttons together cancel
      do_reset();
      sif.btn_up   = 1'b1;
      sif.btn_down = 1'b1;
      cyc(5);
      sif.btn_up   = 1'b0;
      sif.btn_down = 1'b0;
      cyc(20);
      chk("both_level", longint'(sif.level), 1);
      chk("both_period", longint'(sif.period), 1515151);
      $display("txn both: level=%0d period=%0d", sif.level, sif.period);

      // Reset mid-hold: immediate reset values, then the held button re-presses
      do_reset();
      n = edge_cnt;
      sif.btn_up = 1'b1;
      expect_pulse(3'd2, 32'd757575, n + 8);
      cyc(10);
      rst_n = 1'b0;
      #1;
      chk("async_rst_period", longint'(sif.period), 1515151);
      chk("async_rst_level", longint'(sif.level), 1);
      cyc(2);
      rst_n = 1'b1;
      n = edge_cnt;
      expect_pulse(3'd2, 32'd757575, n + 8);
      cyc(1);
      chk("rerst_first_edge_level", longint'(sif.level), 1);
      cyc(11);
      sif.btn_up = 1'b0;
      cyc(12);
      chk("rerst_level", longint'(sif.level), 2);
      chk("rerst_period", longint'(sif.period), 757575);
      $display("txn reset_mid_hold: level=%0d period=%0d", sif.level, sif.period);

      cyc(10);
      chk("sb_drained", longint'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
